// File: rtl/controlador_memoria_dados_if.sv
// Bus bundle between the load/store datapath, the data-memory controller and the data memory.
// The controller takes the slave view; the datapath plus memory side takes the master view.
interface controlador_memoria_dados_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_end;
  logic [DATA_W-1:0] cpu_dado;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_saida;
  logic              ocupado;
  logic              erro;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado;
  logic [DATA_W-1:0] mem_saida;

  modport slave (
    input  cpu_req, cpu_we, cpu_end, cpu_dado, mem_saida,
    output cpu_ack, cpu_saida, ocupado, erro,
           mem_read, mem_write, mem_endereco, mem_dado
  );

  modport master (
    output cpu_req, cpu_we, cpu_end, cpu_dado, mem_saida,
    input  cpu_ack, cpu_saida, ocupado, erro,
           mem_read, mem_write, mem_endereco, mem_dado
  );
endinterface

// File: rtl/controlador_memoria_dados.sv
// Single-request load/store controller for the 8-bit data memory, all outputs registered.
// Define MEM_VERIFY_EN to read back every store and flag mismatches on the sticky erro output.
module controlador_memoria_dados #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic                      clk,
  input logic                      clr,
  controlador_memoria_dados_if.slave bus
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic [DATA_W-1:0] saida_q, saida_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              ack_q, ack_d;
  logic              ocupado_q, ocupado_d;
`ifdef MEM_VERIFY_EN
  logic              we_q, we_d;
  logic              erro_q, erro_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    dado_d  = dado_q;
    saida_d = saida_q;
`ifdef MEM_VERIFY_EN
    we_d    = we_q;
    erro_d  = erro_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          end_d   = bus.cpu_end;
          dado_d  = bus.cpu_dado;
`ifdef MEM_VERIFY_EN
          we_d    = bus.cpu_we;
`endif
          state_d = bus.cpu_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
`ifdef MEM_VERIFY_EN
        state_d = S_READ;
`else
        state_d = S_DONE;
`endif
      end
      S_READ: begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          saida_d = bus.mem_saida;
          state_d = S_DONE;
`ifdef MEM_VERIFY_EN
          // Only store readbacks are compared; plain loads never touch erro.
          if (we_q && (bus.mem_saida != dado_q)) erro_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave flops aligned with it.
    mem_write_d = (state_d == S_WRITE);
    mem_read_d  = (state_d == S_READ) || (state_d == S_WAIT);
    ack_d       = (state_d == S_DONE);
    ocupado_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      end_q       <= '0;
      dado_q      <= '0;
      saida_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack_q       <= 1'b0;
      ocupado_q   <= 1'b0;
`ifdef MEM_VERIFY_EN
      we_q        <= 1'b0;
      erro_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      end_q       <= end_d;
      dado_q      <= dado_d;
      saida_q     <= saida_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ack_q       <= ack_d;
      ocupado_q   <= ocupado_d;
`ifdef MEM_VERIFY_EN
      we_q        <= we_d;
      erro_q      <= erro_d;
`endif
    end
  end

  assign bus.cpu_ack      = ack_q;
  assign bus.cpu_saida    = saida_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_endereco = end_q;
  assign bus.mem_dado     = dado_q;
`ifdef MEM_VERIFY_EN
  assign bus.erro         = erro_q;
`else
  assign bus.erro         = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Randomized bench for controlador_memoria_dados: a latency-true memory model on the bus and a
// transaction-level reference (shadow memory, expected result, expected ack window) for checking.
module tb_controlador_memoria_dados;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 3;
`ifdef MEM_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  controlador_memoria_dados_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  controlador_memoria_dados #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  // Memory: stores land at the edge, reads emerge RD_LAT edges after the address is seen.
  logic [7:0] mem     [256];
  logic [7:0] rd_pipe [RD_LAT];
  logic       corrupt;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_endereco] <= bus.mem_dado ^ {7'd0, corrupt};
    rd_pipe[0] <= mem[bus.mem_endereco];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_saida = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp, n_bad;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_saida;
  logic       exp_erro;
  int         last_acc, exp_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from an idle cycle and follow it to its ack plus the idle cycle after.
  task automatic txn(input bit we, input logic [7:0] a, input logic [7:0] d,
                     input bit hold, input bit chk_gap);
    int n_wr, n_rd, ack_at, exp_ack, exp_rd;
    bit both;
    logic [7:0] stored;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_end  = a;
    bus.cpu_dado = d;
    @(posedge clk); #1;
    if (chk_gap) chk("accept_gap", 32'(cyc - last_acc), 32'(exp_gap));
    last_acc = cyc;
    if (!hold) bus.cpu_req = 1'b0;
    chk("mem_endereco", 32'(bus.mem_endereco), 32'(a));
    chk("mem_dado", 32'(bus.mem_dado), 32'(d));
    chk("ocupado_busy", 32'(bus.ocupado), 32'd1);

    stored = d ^ {7'd0, corrupt};
    if (we) begin
      ref_mem[a] = stored;
      if (VERIFY) begin
        exp_saida = stored;
        if (corrupt) exp_erro = 1'b1;
      end
    end else begin
      exp_saida = ref_mem[a];
    end
    exp_ack = we ? (VERIFY ? 2 + RD_LAT : 1) : 1 + RD_LAT;
    exp_rd  = (we && !VERIFY) ? 0 : 1 + RD_LAT;

    n_wr = 0; n_rd = 0; ack_at = -1; both = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (bus.mem_write) n_wr++;
      if (bus.mem_read) n_rd++;
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      if (bus.cpu_ack) begin ack_at = n; break; end
    end
    chk("ack_window", 32'(ack_at), 32'(exp_ack));
    chk("write_cycles", 32'(n_wr), we ? 32'd1 : 32'd0);
    chk("read_cycles", 32'(n_rd), 32'(exp_rd));
    chk("rw_exclusive", 32'(both), 32'd0);
    chk("cpu_saida", 32'(bus.cpu_saida), 32'(exp_saida));
    chk("erro", 32'(bus.erro), 32'(exp_erro));
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
    chk("ocupado_idle", 32'(bus.ocupado), 32'd0);
    chk("saida_held", 32'(bus.cpu_saida), 32'(exp_saida));
    exp_gap = exp_ack + 2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 32'd0);
    chk({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
    chk({tag, "_erro"}, 32'(bus.erro), 32'd0);
    chk({tag, "_cpu_saida"}, 32'(bus.cpu_saida), 32'd0);
    chk({tag, "_mem_endereco"}, 32'(bus.mem_endereco), 32'd0);
    chk({tag, "_mem_dado"}, 32'(bus.mem_dado), 32'd0);
  endtask

  initial begin
    int acks;
    n_cmp = 0; n_bad = 0;
    corrupt = 1'b0;
    exp_saida = '0; exp_erro = 1'b0;
    last_acc = 0; exp_gap = 0;
    clr = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_end = 8'h33; bus.cpu_dado = 8'hC3;

    // Reset wins over a pending request.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all_zero("reset");
    end
    bus.cpu_req = 1'b0;
    clr = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Directed store then load of the same word.
    txn(1'b1, 8'h10, 8'h5A, 1'b0, 1'b0);
    txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

    // Back-to-back stores with cpu_req held high across every address.
    for (int a = 0; a < 256; a++)
      txn(1'b1, 8'(a), 8'(a + 1), 1'b1, a > 0);
    bus.cpu_req = 1'b0;
    txn(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Reset one cycle into a load aborts it without an ack.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_end = 8'h20;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_all_zero("abort");
    exp_saida = '0; exp_erro = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);

    // Random mix of loads and stores.
    for (int k = 0; k < 60; k++)
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'b0);
    bus.cpu_req = 1'b0;

    // Memory corrupting bit 0: readback mismatch is sticky until reset.
    corrupt = 1'b1;
    txn(1'b1, 8'h44, 8'h80, 1'b0, 1'b0);
    corrupt = 1'b0;
    txn(1'b1, 8'h45, 8'h3C, 1'b0, 1'b0);
    txn(1'b0, 8'h44, 8'h00, 1'b0, 1'b0);
    txn(1'b1, 8'h46, 8'h11, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_all_zero("final_reset");
    exp_saida = '0; exp_erro = 1'b0;
    txn(1'b0, 8'h45, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
